// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Stores a short instruction program and feeds it to the base processor's
// instruction port one word at a time. For an mvi it sends the immediate
// word on the next cycle. It then waits for the processor's done pulse
// before sending the next instruction, and reports completion or an error.
//
// Optional feature:
//   SEQ_WATCHDOG_EN - when defined, a WAIT-state watchdog raises err_code 10
//                     after TIMEOUT cycles without done.
//
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   load_en    in   program word write strobe (IDLE only)
//   load_addr  in   program write address
//   load_data  in   program write data
//   prog_len   in   program length in words, sampled on start
//   start      in   begin execution at address 0 (IDLE only)
//   abort      in   synchronous return to IDLE
//   done       in   processor done pulse
//   run        out  instruction-valid strobe
//   din        out  instruction / immediate word
//   busy       out  high whenever not IDLE
//   pc         out  address of next word to issue
//   prog_done  out  one-cycle pulse on successful completion
//   err        out  sticky error flag, cleared by next accepted start
//   err_code   out  01 truncated mvi, 10 done timeout, 00 none
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
`ifdef SEQ_WATCHDOG_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              done,
  output logic              run,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic [AW:0]       pc,
  output logic              prog_done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {IDLE, ISSUE, IMM, WAIT} state_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] TWO     = (AW+1)'(2);
  localparam logic [2:0]  OP_MVI  = 3'b001;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [AW:0]       len, len_nxt;
  logic [AW:0]       pc_nxt;
  logic              run_nxt, prog_done_nxt, err_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic [1:0]        err_code_nxt;

  logic [AW:0]       sat_len, pc_inc;
  logic [AW:0]       tgt_addr, tgt_len, tgt_inc;
  logic [DATA_W-1:0] tgt_word, cur_word, imm_word;
  logic              tgt_trunc;

`ifdef SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wd_cnt, wd_cnt_nxt;
`endif

  // Program memory: plain register array, written only while idle, never reset.
  always_ff @(posedge clock) begin
    if (load_en && state == IDLE)
      mem[load_addr] <= load_data;
  end

  // Lengths beyond the memory size are clamped so pc never walks off the end.
  assign sat_len  = (prog_len > DEPTH_V) ? DEPTH_V : prog_len;
  assign pc_inc   = pc + ONE;
  assign cur_word = mem[pc[AW-1:0]];
  assign imm_word = mem[pc_inc[AW-1:0]];

  // The word about to enter ISSUE is looked at one cycle early. This lets run
  // be a registered output and still stay low for an mvi whose immediate
  // falls outside the program.
  assign tgt_addr  = (state == IDLE) ? '0 : pc;
  assign tgt_len   = (state == IDLE) ? sat_len : len;
  assign tgt_inc   = tgt_addr + ONE;
  assign tgt_word  = mem[tgt_addr[AW-1:0]];
  assign tgt_trunc = (tgt_word[8:6] == OP_MVI) && (tgt_inc >= tgt_len);

  // State and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      len       <= '0;
      pc        <= '0;
      run       <= 1'b0;
      din       <= '0;
      busy      <= 1'b0;
      prog_done <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      pc        <= pc_nxt;
      run       <= run_nxt;
      din       <= din_nxt;
      busy      <= (state_nxt != IDLE);
      prog_done <= prog_done_nxt;
      err       <= err_nxt;
      err_code  <= err_code_nxt;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt    <= wd_cnt_nxt;
`endif
    end
  end

  // Next-state logic and next values of the outputs. Abort has the highest
  // priority, so a done in the same cycle is dropped.
  always_comb begin
    state_nxt     = state;
    len_nxt       = len;
    pc_nxt        = pc;
    run_nxt       = 1'b0;
    din_nxt       = din;
    prog_done_nxt = 1'b0;
    err_nxt       = err;
    err_code_nxt  = err_code;
`ifdef SEQ_WATCHDOG_EN
    wd_cnt_nxt    = wd_cnt;
`endif
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_nxt      = 1'b0;
            err_code_nxt = 2'b00;
            pc_nxt       = '0;
            len_nxt      = sat_len;
            if (sat_len == '0) begin
              prog_done_nxt = 1'b1;
            end else begin
              state_nxt = ISSUE;
              run_nxt   = !tgt_trunc;
              din_nxt   = tgt_word;
            end
          end
        end
        ISSUE: begin
          if (cur_word[8:6] == OP_MVI) begin
            if (pc_inc >= len) begin
              err_nxt      = 1'b1;
              err_code_nxt = 2'b01;
              state_nxt    = IDLE;
            end else begin
              state_nxt = IMM;
              din_nxt   = imm_word;
            end
          end else begin
            pc_nxt    = pc_inc;
            state_nxt = WAIT;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt_nxt = '0;
`endif
          end
        end
        IMM: begin
          pc_nxt    = pc + TWO;
          state_nxt = WAIT;
`ifdef SEQ_WATCHDOG_EN
          wd_cnt_nxt = '0;
`endif
        end
        WAIT: begin
          if (done) begin
            if (pc >= len) begin
              prog_done_nxt = 1'b1;
              state_nxt     = IDLE;
            end else begin
              state_nxt = ISSUE;
              run_nxt   = !tgt_trunc;
              din_nxt   = tgt_word;
            end
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'b10;
            state_nxt    = IDLE;
          end else begin
            wd_cnt_nxt = wd_cnt + 1'b1;
          end
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer. Each scenario task drives its own
// stimulus and compares outputs against hand-computed values. Outputs are
// sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clock = 1'b0;
  logic              resetn;
  logic              load_en;
  logic [AW-1:0]     load_addr;
  logic [DATA_W-1:0] load_data;
  logic [AW:0]       prog_len;
  logic              start, abort, done;
  logic              run, busy, prog_done, err;
  logic [DATA_W-1:0] din;
  logic [AW:0]       pc;
  logic [1:0]        err_code;

  int n_compared   = 0;
  int n_mismatched = 0;
  int run_cnt      = 0;

  instr_sequencer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
`ifdef SEQ_WATCHDOG_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .prog_len (prog_len),
    .start    (start),
    .abort    (abort),
    .done     (done),
    .run      (run),
    .din      (din),
    .busy     (busy),
    .pc       (pc),
    .prog_done(prog_done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clock = ~clock;

  // Counts run pulses; run is a full-cycle registered strobe, so one count per pulse.
  always @(negedge clock) if (run === 1'b1) run_cnt++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW:0] len);
    prog_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_compared++;
    if ({run, din, busy, pc, prog_done, err, err_code} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got run=%b din=%h busy=%b pc=%0d pd=%b err=%b code=%b, expected all zero",
               run, din, busy, pc, prog_done, err, err_code);
    end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    int base;
    load_word(0, 16'h0001);
    base = run_cnt;
    pulse_start(1);
    n_compared++;
    if ({run, din, busy} !== {1'b1, 16'h0001, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL single_issue: got run=%b din=%h busy=%b, expected run=1 din=0001 busy=1", run, din, busy);
    end
    tick(); tick(); tick();
    n_compared++;
    if ({run, pc} !== {1'b0, 5'd1}) begin
      n_mismatched++;
      $display("[TB] FAIL single_wait: got run=%b pc=%0d, expected run=0 pc=1", run, pc);
    end
    pulse_done();
    n_compared++;
    if ({prog_done, busy, pc} !== {1'b1, 1'b0, 5'd1}) begin
      n_mismatched++;
      $display("[TB] FAIL single_done: got pd=%b busy=%b pc=%0d, expected pd=1 busy=0 pc=1", prog_done, busy, pc);
    end
    tick();
    n_compared++;
    if ({prog_done, run_cnt - base} !== {1'b0, 32'd1}) begin
      n_mismatched++;
      $display("[TB] FAIL single_pulse: got pd=%b runs=%0d, expected pd=0 runs=1", prog_done, run_cnt - base);
    end
  endtask

  task automatic load_mvi_prog();
    load_word(0, 16'h0040);
    load_word(1, 16'h000F);
    load_word(2, 16'h009A);
    load_word(3, 16'h00FE);
  endtask

  task automatic test_mvi();
    int base;
    load_mvi_prog();
    base = run_cnt;
    pulse_start(4);
    n_compared++;
    if ({run, din, pc} !== {1'b1, 16'h0040, 5'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL mvi_issue: got run=%b din=%h pc=%0d, expected run=1 din=0040 pc=0", run, din, pc);
    end
    tick();
    n_compared++;
    if ({run, din} !== {1'b0, 16'h000F}) begin
      n_mismatched++;
      $display("[TB] FAIL mvi_imm: got run=%b din=%h, expected run=0 din=000f", run, din);
    end
    tick(); tick(); tick();
    n_compared++;
    if ({run, pc, run_cnt - base} !== {1'b0, 5'd2, 32'd1}) begin
      n_mismatched++;
      $display("[TB] FAIL mvi_hold: got run=%b pc=%0d runs=%0d, expected run=0 pc=2 runs=1", run, pc, run_cnt - base);
    end
    pulse_done();
    n_compared++;
    if ({run, din, pc} !== {1'b1, 16'h009A, 5'd2}) begin
      n_mismatched++;
      $display("[TB] FAIL mvi_add: got run=%b din=%h pc=%0d, expected run=1 din=009a pc=2", run, din, pc);
    end
    tick();
    pulse_done();
    n_compared++;
    if ({run, din, pc} !== {1'b1, 16'h00FE, 5'd3}) begin
      n_mismatched++;
      $display("[TB] FAIL mvi_sub: got run=%b din=%h pc=%0d, expected run=1 din=00fe pc=3", run, din, pc);
    end
    tick();
    pulse_done();
    n_compared++;
    if ({prog_done, pc, err, busy, run_cnt - base} !== {1'b1, 5'd4, 1'b0, 1'b0, 32'd3}) begin
      n_mismatched++;
      $display("[TB] FAIL mvi_end: got pd=%b pc=%0d err=%b busy=%b runs=%0d, expected pd=1 pc=4 err=0 busy=0 runs=3",
               prog_done, pc, err, busy, run_cnt - base);
    end
  endtask

  task automatic test_truncated_mvi();
    int base;
    load_word(0, 16'h0040);
    base = run_cnt;
    pulse_start(1);
    n_compared++;
    if ({run, busy} !== {1'b0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL trunc_issue: got run=%b busy=%b, expected run=0 busy=1", run, busy);
    end
    tick();
    n_compared++;
    if ({busy, err, err_code, prog_done} !== {1'b0, 1'b1, 2'b01, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL trunc_err: got busy=%b err=%b code=%b pd=%b, expected busy=0 err=1 code=01 pd=0",
               busy, err, err_code, prog_done);
    end
    tick();
    n_compared++;
    if ({err, prog_done, run_cnt - base} !== {1'b1, 1'b0, 32'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL trunc_sticky: got err=%b pd=%b runs=%0d, expected err=1 pd=0 runs=0", err, prog_done, run_cnt - base);
    end
  endtask

  task automatic test_zero_len();
    pulse_start(0);
    n_compared++;
    if ({prog_done, run, busy, err, err_code} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      n_mismatched++;
      $display("[TB] FAIL zero_len: got pd=%b run=%b busy=%b err=%b code=%b, expected pd=1 run=0 busy=0 err=0 code=00",
               prog_done, run, busy, err, err_code);
    end
    tick();
  endtask

  task automatic test_abort();
    load_mvi_prog();
    pulse_start(4);
    tick(); tick();
    done = 1'b1; abort = 1'b1;
    tick();
    done = 1'b0; abort = 1'b0;
    n_compared++;
    if ({run, prog_done, busy, pc} !== {1'b0, 1'b0, 1'b0, 5'd2}) begin
      n_mismatched++;
      $display("[TB] FAIL abort_beats_done: got run=%b pd=%b busy=%b pc=%0d, expected run=0 pd=0 busy=0 pc=2",
               run, prog_done, busy, pc);
    end
    tick();
    n_compared++;
    if (prog_done !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_no_done: got pd=%b, expected pd=0", prog_done);
    end
    pulse_start(4);
    n_compared++;
    if ({run, din, pc} !== {1'b1, 16'h0040, 5'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL abort_restart: got run=%b din=%h pc=%0d, expected run=1 din=0040 pc=0", run, din, pc);
    end
  endtask

  task automatic test_reset_mid();
    tick(); tick();
    resetn = 1'b0;
    #1;
    n_compared++;
    if ({run, busy, pc, err, prog_done, din} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid: got run=%b busy=%b pc=%0d err=%b pd=%b din=%h, expected all zero",
               run, busy, pc, err, prog_done, din);
    end
    #2;
    resetn = 1'b1;
    load_word(0, 16'h00AB);
  endtask

  task automatic test_ignored();
    pulse_start(1);
    n_compared++;
    if ({run, din} !== {1'b1, 16'h00AB}) begin
      n_mismatched++;
      $display("[TB] FAIL load_after_reset: got run=%b din=%h, expected run=1 din=00ab", run, din);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    load_en = 1'b1; load_addr = 0; load_data = 16'h01FF;
    prog_len = 3; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    n_compared++;
    if ({busy, run, pc, prog_done} !== {1'b1, 1'b0, 5'd1, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL busy_ignores: got busy=%b run=%b pc=%0d pd=%b, expected busy=1 run=0 pc=1 pd=0",
               busy, run, pc, prog_done);
    end
    pulse_done();
    n_compared++;
    if ({prog_done, pc} !== {1'b1, 5'd1}) begin
      n_mismatched++;
      $display("[TB] FAIL ignored_done: got pd=%b pc=%0d, expected pd=1 pc=1", prog_done, pc);
    end
    pulse_start(1);
    n_compared++;
    if (din !== 16'h00AB) begin
      n_mismatched++;
      $display("[TB] FAIL load_while_busy: got din=%h, expected din=00ab", din);
    end
    tick();
    pulse_done();
  endtask

  task automatic test_saturate();
    int base;
    for (int i = 0; i < DEPTH; i++) load_word(i[AW-1:0], 16'h0010 + 16'(i));
    base = run_cnt;
    pulse_start(5'd31);
    for (int i = 0; i < DEPTH; i++) begin
      n_compared++;
      if ({run, din} !== {1'b1, 16'h0010 + 16'(i)}) begin
        n_mismatched++;
        $display("[TB] FAIL sat_issue_%0d: got run=%b din=%h, expected run=1 din=%h", i, run, din, 16'h0010 + 16'(i));
      end
      tick();
      pulse_done();
    end
    n_compared++;
    if ({prog_done, pc, busy, run_cnt - base} !== {1'b1, 5'd16, 1'b0, 32'd16}) begin
      n_mismatched++;
      $display("[TB] FAIL sat_end: got pd=%b pc=%0d busy=%b runs=%0d, expected pd=1 pc=16 busy=0 runs=16",
               prog_done, pc, busy, run_cnt - base);
    end
  endtask

  task automatic test_watchdog();
    int low_cycles;
    load_word(0, 16'h0001);
    pulse_start(1);
    tick();
`ifdef SEQ_WATCHDOG_EN
    low_cycles = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (err !== 1'b0 || busy !== 1'b1) low_cycles++;
    end
    n_compared++;
    if (low_cycles !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL wd_early: got %0d early-error cycles, expected 0", low_cycles);
    end
    tick();
    n_compared++;
    if ({err, err_code, busy, prog_done} !== {1'b1, 2'b10, 1'b0, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL wd_timeout: got err=%b code=%b busy=%b pd=%b, expected err=1 code=10 busy=0 pd=0",
               err, err_code, busy, prog_done);
    end
`else
    low_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (busy !== 1'b1 || err !== 1'b0) low_cycles++;
    end
    n_compared++;
    if (low_cycles !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL no_wd_hold: got %0d cycles not busy or in error, expected 0", low_cycles);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_compared++;
    if ({busy, err_code} !== {1'b0, 2'b00}) begin
      n_mismatched++;
      $display("[TB] FAIL no_wd_abort: got busy=%b code=%b, expected busy=0 code=00", busy, err_code);
    end
`endif
  endtask

  initial begin
    resetn = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0; done = 1'b0;
    test_reset();
    test_single();
    test_mvi();
    test_truncated_mvi();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_ignored();
    test_saturate();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
